// File: rtl/pipeline_hazard_controller_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_e              : sequencer state encoding
//   DEFAULT_LOAD_STALL_CYCLES : bubbles per load-use hazard (forwarding build)
//   BUBBLE_W                  : width of the bubble down-counter (holds 0..3)
// ---------------------------------------------------------------------------
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2
  } ctrl_state_e;

  localparam int DEFAULT_LOAD_STALL_CYCLES = 1;
  localparam int BUBBLE_W                  = 2;

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller_if
// Bundles hazard sources and the stall/flush controls of the 5-stage pipeline.
//   Hazard sources (pipeline -> controller):
//     BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD, EX_MEM_READ,
//     BRANCH_TAKEN
//   Controls (controller -> pipeline):
//     PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
//     IF_ID_FLUSH, ID_EX_FLUSH, PC_REDIRECT, STALL_COUNT, FLUSH_COUNT
//   master : pipeline side, slave : hazard controller
// ---------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
  parameter int COUNTER_WIDTH = 32
);

  logic                     BUSYWAIT;
  logic [4:0]               ID_RS1;
  logic [4:0]               ID_RS2;
  logic                     ID_USES_RS1;
  logic                     ID_USES_RS2;
  logic [4:0]               EX_RD;
  logic                     EX_MEM_READ;
  logic                     BRANCH_TAKEN;

  logic                     PC_HOLD;
  logic                     IF_ID_HOLD;
  logic                     ID_EX_HOLD;
  logic                     EX_MEM_HOLD;
  logic                     MEM_WB_HOLD;
  logic                     IF_ID_FLUSH;
  logic                     ID_EX_FLUSH;
  logic                     PC_REDIRECT;
  logic [COUNTER_WIDTH-1:0] STALL_COUNT;
  logic [COUNTER_WIDTH-1:0] FLUSH_COUNT;

  modport master (
    output BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD,
           EX_MEM_READ, BRANCH_TAKEN,
    input  PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
           IF_ID_FLUSH, ID_EX_FLUSH, PC_REDIRECT, STALL_COUNT, FLUSH_COUNT
  );

  modport slave (
    input  BUSYWAIT, ID_RS1, ID_RS2, ID_USES_RS1, ID_USES_RS2, EX_RD,
           EX_MEM_READ, BRANCH_TAKEN,
    output PC_HOLD, IF_ID_HOLD, ID_EX_HOLD, EX_MEM_HOLD, MEM_WB_HOLD,
           IF_ID_FLUSH, ID_EX_FLUSH, PC_REDIRECT, STALL_COUNT, FLUSH_COUNT
  );

endinterface

// File: rtl/pipeline_hazard_controller_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Event counter that sticks at all-ones instead of wrapping.
//   clk   : clock, rising edge
//   clear : synchronous clear (highest priority)
//   inc   : count one event this cycle
//   count : current value
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clear) begin
      count_reg <= '0;
    end else if (inc && (count_reg != '1)) begin
      count_reg <= count_reg + WIDTH'(1);
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_controller
// Central stall/flush sequencer for the 5-stage RV32 pipeline. Every control
// output is combinational from the registered sequencer state and the current
// hazard inputs; priority is RESET > BUSYWAIT > redirect > load-use.
//   CLK   : clock, rising edge
//   RESET : synchronous, active-high
//   bus   : pipeline_hazard_controller_if.slave (hazard sources in,
//           hold/flush/redirect controls and perf counters out)
// LOAD_STALL_CYCLES: bubbles per load-use hazard, 1..3.
// ---------------------------------------------------------------------------
module pipeline_hazard_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = DEFAULT_LOAD_STALL_CYCLES,
  parameter int COUNTER_WIDTH     = 32
) (
  input  logic                          CLK,
  input  logic                          RESET,
  pipeline_hazard_controller_if.slave   bus
);

  localparam logic [BUBBLE_W-1:0] BUBBLE_LOAD = BUBBLE_W'(LOAD_STALL_CYCLES - 1);

  ctrl_state_e          state_reg,   state_next;
  ctrl_state_e          saved_reg,   saved_next;
  logic [BUBBLE_W-1:0]  bubble_reg,  bubble_next;
  logic                 pending_reg, pending_next;

  // hold[0..4] = PC, IF_ID, ID_EX, EX_MEM, MEM_WB
  logic [4:0]           hold;
  logic                 flush_if_id;
  logic                 flush_id_ex;
  logic                 redirect;
  logic                 load_use;
  logic                 in_stall;

  assign load_use = bus.EX_MEM_READ && (bus.EX_RD != 5'd0) &&
                    ((bus.ID_USES_RS1 && (bus.EX_RD == bus.ID_RS1)) ||
                     (bus.ID_USES_RS2 && (bus.EX_RD == bus.ID_RS2)));

  // A wait that interrupted a load stall resumes it only while bubbles remain.
  assign in_stall = (state_reg == LOAD_STALL) ||
                    ((state_reg == MEM_WAIT) && (saved_reg == LOAD_STALL) &&
                     (bubble_reg != '0));

  always_comb begin
    state_next   = state_reg;
    saved_next   = saved_reg;
    bubble_next  = bubble_reg;
    pending_next = pending_reg;
    hold         = 5'b00000;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    redirect     = 1'b0;

    if (RESET) begin
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      state_next   = RUN;
      saved_next   = RUN;
      bubble_next  = '0;
      pending_next = 1'b0;
    end else if (bus.BUSYWAIT) begin
      hold       = 5'b11111;
      state_next = MEM_WAIT;
      // Only the state in force when the wait began is remembered.
      if (state_reg != MEM_WAIT) begin
        saved_next = state_reg;
      end
      // EX is frozen, so a taken branch seen now must be replayed on release.
      if (bus.BRANCH_TAKEN) begin
        pending_next = 1'b1;
      end
    end else if (pending_reg || bus.BRANCH_TAKEN) begin
      // Redirect squashes the ID instruction, so any load-use is moot.
      redirect     = 1'b1;
      flush_if_id  = 1'b1;
      flush_id_ex  = 1'b1;
      state_next   = RUN;
      saved_next   = RUN;
      bubble_next  = '0;
      pending_next = 1'b0;
    end else if (in_stall) begin
      hold[0]     = 1'b1;
      hold[1]     = 1'b1;
      flush_id_ex = 1'b1;
      bubble_next = (bubble_reg != '0) ? (bubble_reg - BUBBLE_W'(1)) : '0;
      state_next  = (bubble_reg <= BUBBLE_W'(1)) ? RUN : LOAD_STALL;
    end else if (load_use) begin
      hold[0]     = 1'b1;
      hold[1]     = 1'b1;
      flush_id_ex = 1'b1;
      bubble_next = BUBBLE_LOAD;
      state_next  = (LOAD_STALL_CYCLES == 1) ? RUN : LOAD_STALL;
    end else begin
      state_next = RUN;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= RUN;
      saved_reg   <= RUN;
      bubble_reg  <= '0;
      pending_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      saved_reg   <= saved_next;
      bubble_reg  <= bubble_next;
      pending_reg <= pending_next;
    end
  end

  // Counter 0 counts PC_HOLD cycles, counter 1 counts redirects.
  logic [1:0]               cnt_inc;
  logic [COUNTER_WIDTH-1:0] cnt_val [2];

  assign cnt_inc[0] = hold[0] && !RESET;
  assign cnt_inc[1] = redirect;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_cnt
      sat_counter #(
        .WIDTH (COUNTER_WIDTH)
      ) u_cnt (
        .clk   (CLK),
        .clear (RESET),
        .inc   (cnt_inc[gi]),
        .count (cnt_val[gi])
      );
    end
  endgenerate

  assign bus.PC_HOLD     = hold[0];
  assign bus.IF_ID_HOLD  = hold[1];
  assign bus.ID_EX_HOLD  = hold[2];
  assign bus.EX_MEM_HOLD = hold[3];
  assign bus.MEM_WB_HOLD = hold[4];
  assign bus.IF_ID_FLUSH = flush_if_id;
  assign bus.ID_EX_FLUSH = flush_id_ex;
  assign bus.PC_REDIRECT = redirect;
  assign bus.STALL_COUNT = cnt_val[0];
  assign bus.FLUSH_COUNT = cnt_val[1];

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// ---------------------------------------------------------------------------
// tb_pipeline_hazard_controller
// Three controllers share one stimulus stream: 1, 2 and 3 bubbles per
// load-use hazard, the last with 3-bit counters so saturation is reachable.
// A cycle-level reference model predicts controls and counters.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       busy = 1'b0;
  logic       br = 1'b0;
  logic       mrd = 1'b0;
  logic [4:0] rd = 5'd0;
  logic [4:0] rs1 = 5'd0;
  logic [4:0] rs2 = 5'd0;
  logic       us1 = 1'b0;
  logic       us2 = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.COUNTER_WIDTH(32)) b1 ();
  pipeline_hazard_controller_if #(.COUNTER_WIDTH(32)) b2 ();
  pipeline_hazard_controller_if #(.COUNTER_WIDTH(3))  b3 ();

  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(1), .COUNTER_WIDTH(32))
    u1 (.CLK(clk), .RESET(rst), .bus(b1.slave));
  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(2), .COUNTER_WIDTH(32))
    u2 (.CLK(clk), .RESET(rst), .bus(b2.slave));
  pipeline_hazard_controller #(.LOAD_STALL_CYCLES(3), .COUNTER_WIDTH(3))
    u3 (.CLK(clk), .RESET(rst), .bus(b3.slave));

  assign b1.BUSYWAIT = busy;   assign b2.BUSYWAIT = busy;   assign b3.BUSYWAIT = busy;
  assign b1.BRANCH_TAKEN = br; assign b2.BRANCH_TAKEN = br; assign b3.BRANCH_TAKEN = br;
  assign b1.EX_MEM_READ = mrd; assign b2.EX_MEM_READ = mrd; assign b3.EX_MEM_READ = mrd;
  assign b1.EX_RD = rd;        assign b2.EX_RD = rd;        assign b3.EX_RD = rd;
  assign b1.ID_RS1 = rs1;      assign b2.ID_RS1 = rs1;      assign b3.ID_RS1 = rs1;
  assign b1.ID_RS2 = rs2;      assign b2.ID_RS2 = rs2;      assign b3.ID_RS2 = rs2;
  assign b1.ID_USES_RS1 = us1; assign b2.ID_USES_RS1 = us1; assign b3.ID_USES_RS1 = us1;
  assign b1.ID_USES_RS2 = us2; assign b2.ID_USES_RS2 = us2; assign b3.ID_USES_RS2 = us2;

  // Control bits: {PC, IF_ID, ID_EX, EX_MEM, MEM_WB holds, IF_ID_FLUSH, ID_EX_FLUSH, PC_REDIRECT}
  logic [7:0]  ctl_obs [3];
  logic [31:0] sc_obs  [3];
  logic [31:0] fc_obs  [3];

  assign ctl_obs[0] = {b1.PC_HOLD, b1.IF_ID_HOLD, b1.ID_EX_HOLD, b1.EX_MEM_HOLD, b1.MEM_WB_HOLD,
                       b1.IF_ID_FLUSH, b1.ID_EX_FLUSH, b1.PC_REDIRECT};
  assign ctl_obs[1] = {b2.PC_HOLD, b2.IF_ID_HOLD, b2.ID_EX_HOLD, b2.EX_MEM_HOLD, b2.MEM_WB_HOLD,
                       b2.IF_ID_FLUSH, b2.ID_EX_FLUSH, b2.PC_REDIRECT};
  assign ctl_obs[2] = {b3.PC_HOLD, b3.IF_ID_HOLD, b3.ID_EX_HOLD, b3.EX_MEM_HOLD, b3.MEM_WB_HOLD,
                       b3.IF_ID_FLUSH, b3.ID_EX_FLUSH, b3.PC_REDIRECT};
  assign sc_obs[0] = b1.STALL_COUNT;
  assign sc_obs[1] = b2.STALL_COUNT;
  assign sc_obs[2] = {29'd0, b3.STALL_COUNT};
  assign fc_obs[0] = b1.FLUSH_COUNT;
  assign fc_obs[1] = b2.FLUSH_COUNT;
  assign fc_obs[2] = {29'd0, b3.FLUSH_COUNT};

  // Reference model: remaining stall cycles, deferred redirect, event totals.
  int     bubbles [3] = '{1, 2, 3};
  longint cmax    [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd7};
  int     left    [3] = '{0, 0, 0};
  bit     pend    [3] = '{0, 0, 0};
  longint sc      [3] = '{0, 0, 0};
  longint fc      [3] = '{0, 0, 0};

  task automatic apply(input bit r, input bit bz, input bit b, input bit mr,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                       input bit u1_in, input bit u2_in);
    bit lu;
    rst = r; busy = bz; br = b; mrd = mr; rd = d; rs1 = s1; rs2 = s2;
    us1 = u1_in; us2 = u2_in;
    lu = mr && (d != 5'd0) && ((u1_in && (d == s1)) || (u2_in && (d == s2)));
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      logic [7:0] e;
      if (r)                    e = 8'b0000_0110;
      else if (bz)              e = 8'b1111_1000;
      else if (pend[k] || b)    e = 8'b0000_0111;
      else if (left[k] > 0 || lu) e = 8'b1100_0010;
      else                      e = 8'b0000_0000;

      vectors++;
      assert (ctl_obs[k] === e) else begin
        miscompares++;
        $error("FAIL d%0d_ctl cyc=%0d observed=%b expected=%b", k + 1, cyc, ctl_obs[k], e);
      end
      vectors++;
      assert (sc_obs[k] === 32'(sc[k])) else begin
        miscompares++;
        $error("FAIL d%0d_stall_count cyc=%0d observed=%0d expected=%0d", k + 1, cyc, sc_obs[k], sc[k]);
      end
      vectors++;
      assert (fc_obs[k] === 32'(fc[k])) else begin
        miscompares++;
        $error("FAIL d%0d_flush_count cyc=%0d observed=%0d expected=%0d", k + 1, cyc, fc_obs[k], fc[k]);
      end

      if (r) begin
        left[k] = 0; pend[k] = 0; sc[k] = 0; fc[k] = 0;
      end else if (bz) begin
        pend[k] = pend[k] | b;
        if (sc[k] < cmax[k]) sc[k]++;
      end else if (pend[k] || b) begin
        pend[k] = 0; left[k] = 0;
        if (fc[k] < cmax[k]) fc[k]++;
      end else if (left[k] > 0) begin
        left[k]--;
        if (sc[k] < cmax[k]) sc[k]++;
      end else if (lu) begin
        left[k] = bubbles[k] - 1;
        if (sc[k] < cmax[k]) sc[k]++;
      end
    end
    $display("cyc=%0d rst=%0b busy=%0b br=%0b lu=%0b ctl=%b/%b/%b stall=%0d/%0d/%0d flush=%0d/%0d/%0d",
             cyc, r, bz, b, lu, ctl_obs[0], ctl_obs[1], ctl_obs[2],
             sc_obs[0], sc_obs[1], sc_obs[2], fc_obs[0], fc_obs[1], fc_obs[2]);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    apply(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    // Reset, then a quiet cycle
    apply(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    apply(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    // Load-use on rs2 = x5, EX cleared afterwards: 1/2/3 stall cycles
    apply(0, 0, 0, 1, 5'd5, 5'd0, 5'd5, 0, 1);
    repeat (3) idle();
    // Branch together with a load-use match: redirect wins
    apply(0, 0, 1, 1, 5'd7, 5'd7, 5'd0, 1, 0);
    idle();
    // Three-cycle memory wait with a taken branch in the middle
    apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    apply(0, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    idle();
    // Reset in the middle of a load stall
    apply(0, 0, 0, 1, 5'd9, 5'd9, 5'd0, 1, 0);
    apply(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    idle();
    // x0 destination and non-load producers never stall
    apply(0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    apply(0, 0, 0, 0, 5'd3, 5'd3, 5'd3, 1, 1);
    // Load stall interrupted by a memory wait, then resumed
    apply(0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 1, 0);
    apply(0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    repeat (4) idle();

    // Randomized traffic with small register indices to provoke matches
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(99) < 2,
            $urandom_range(99) < 20,
            $urandom_range(99) < 10,
            $urandom_range(99) < 50,
            5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
            $urandom_range(99) < 70,
            $urandom_range(99) < 70);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
